// File: rtl/vending_return_sequencer_pkg.sv
// Shared vending definitions: coin table, balance width and change-path FSM encoding.
package vending_return_sequencer_pkg;

    localparam int kNumCoins  = 3;
    localparam int kNumItems  = 4;
    localparam int kTotalBits = 16;

    // Ascending order: index 0 is the smallest denomination.
    localparam logic [kTotalBits-1:0] kCoinValue [kNumCoins] = '{16'd100, 16'd500, 16'd1000};
    localparam logic [kTotalBits-1:0] kMinCoinValue = 16'd100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RETURN = 2'd2
    } ret_state_e;

endpackage

// File: rtl/vending_return_sequencer_coin_picker.sv
// Greedy change selector: largest coin that fits in the balance, one-hot plus its value.
// Latency: combinational.
// Backpressure: none; zero coin/value when the balance is below the smallest coin.
module change_coin_picker
    import vending_return_sequencer_pkg::*;
(
    input  logic [kTotalBits-1:0] i_total,
    output logic [kNumCoins-1:0]  o_coin,
    output logic [kTotalBits-1:0] o_value
);

    // Ascending scan, so the last coin that fits (the largest) wins and the result stays one-hot.
    always_comb begin
        o_coin  = '0;
        o_value = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (i_total >= kCoinValue[k]) begin
                o_coin    = '0;
                o_coin[k] = 1'b1;
                o_value   = kCoinValue[k];
            end
        end
    end

endmodule

// File: rtl/vending_return_sequencer.sv
// Change-path control: inactivity timer plus IDLE/ACTIVE/RETURN FSM returning one coin per cycle.
// Latency: trigger or timer expiry -> RETURN next cycle; n coins over n cycles, IDLE two cycles later.
// Backpressure: none; the output stage must apply o_total_dec every cycle it is nonzero.
module vending_return_sequencer
    import vending_return_sequencer_pkg::*;
#(
    parameter int WAIT_TIME = 100,
    parameter int WAIT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [kNumCoins-1:0]  i_input_coin,
    input  logic [kNumItems-1:0]  i_select_item,
    input  logic                  i_item_dispensed,
    input  logic                  i_trigger_return,
    input  logic [kTotalBits-1:0] i_current_total,
    output logic                  o_return_changes,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic [kTotalBits-1:0] o_total_dec,
    output logic [WAIT_W-1:0]     o_wait_time,
    output logic                  o_busy
);

    localparam logic [WAIT_W-1:0] kWaitLoad = WAIT_W'(WAIT_TIME);

    ret_state_e              state_q, state_d;
    logic [WAIT_W-1:0]       timer_q, timer_d;
    logic                    activity;
    logic                    has_change;
    logic                    in_return;
    logic [kNumCoins-1:0]    pick_coin;
    logic [kTotalBits-1:0]   pick_value;
    logic                    unused_select;

    // Item selection only matters once the output stage reports a dispense.
    assign unused_select = ^i_select_item;

    assign activity   = (|i_input_coin) | i_item_dispensed;
    assign has_change = (i_current_total >= kMinCoinValue);
    assign in_return  = (state_q == ST_RETURN);

    change_coin_picker u_picker (
        .i_total (i_current_total),
        .o_coin  (pick_coin),
        .o_value (pick_value)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_trigger_return && has_change) begin
                    state_d = ST_RETURN;
                    timer_d = '0;
                end else if (activity) begin
                    state_d = ST_ACTIVE;
                    timer_d = kWaitLoad;
                end
            end
            ST_ACTIVE: begin
                // A coin arriving with the trigger is still banked by the datapath; the trigger wins here.
                if (i_trigger_return) begin
                    state_d = ST_RETURN;
                    timer_d = '0;
                end else if (activity) begin
                    timer_d = kWaitLoad;
                end else if (timer_q == '0) begin
                    state_d = ST_RETURN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_RETURN: begin
                timer_d = '0;
                if (!has_change) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Coin outputs are gated by the registered state, so reset clears them without a clock edge.
    assign o_return_changes = in_return;
    assign o_return_coin    = in_return ? pick_coin  : '0;
    assign o_total_dec      = in_return ? pick_value : '0;
    assign o_wait_time      = timer_q;
    assign o_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vending_return_sequencer.sv
// Bench for the change-path sequencer: holds the balance register itself and checks against a greedy change model.
module tb_vending_return_sequencer;
    import vending_return_sequencer_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [kNumCoins-1:0]  i_input_coin = '0;
    logic [kNumItems-1:0]  i_select_item = '0;
    logic                  i_item_dispensed = 1'b0;
    logic                  i_trigger_return = 1'b0;
    logic [kTotalBits-1:0] cur_total;
    logic                  o_return_changes;
    logic [kNumCoins-1:0]  o_return_coin;
    logic [kTotalBits-1:0] o_total_dec;
    logic [7:0]            o_wait_time;
    logic                  o_busy;

    int checks   = 0;
    int failures = 0;
    int val_tab [3] = '{100, 500, 1000};

    logic                  set_vld = 1'b0;
    logic [kTotalBits-1:0] set_val = '0;

    typedef struct {
        logic                  chg;
        logic [kNumCoins-1:0]  coin;
        logic [kTotalBits-1:0] dec;
    } exp_t;
    exp_t exp_q[$];

    vending_return_sequencer #(.WAIT_TIME(100), .WAIT_W(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_item_dispensed (i_item_dispensed),
        .i_trigger_return (i_trigger_return),
        .i_current_total  (cur_total),
        .o_return_changes (o_return_changes),
        .o_return_coin    (o_return_coin),
        .o_total_dec      (o_total_dec),
        .o_wait_time      (o_wait_time),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    function automatic int coin_sum(input logic [2:0] c);
        int s = 0;
        for (int k = 0; k < 3; k++) if (c[k]) s += val_tab[k];
        return s;
    endfunction

    // Output-stage balance register.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cur_total <= '0;
        else if (set_vld) cur_total <= set_val;
        else              cur_total <= kTotalBits'(int'(cur_total) + coin_sum(i_input_coin) - int'(o_total_dec));
    end

    // Expected per-cycle view of a return: counts per denomination by division, then a
    // closing cycle with no coin, then idle. Returns the residue left in the balance.
    function automatic int model_return(input int total);
        int   rem;
        exp_t e;
        rem = total;
        exp_q.delete();
        for (int k = 2; k >= 0; k--) begin
            int n;
            n   = rem / val_tab[k];
            rem = rem % val_tab[k];
            for (int j = 0; j < n; j++) begin
                e.chg  = 1'b1;
                e.coin = 3'(1 << k);
                e.dec  = 16'(val_tab[k]);
                exp_q.push_back(e);
            end
        end
        e.chg = 1'b1; e.coin = '0; e.dec = '0;
        exp_q.push_back(e);
        e.chg = 1'b0;
        exp_q.push_back(e);
        return rem;
    endfunction

    task automatic set_total(input int v);
        set_vld = 1'b1;
        set_val = 16'(v);
        @(negedge clk);
        set_vld = 1'b0;
    endtask

    task automatic trigger();
        i_trigger_return = 1'b1;
        @(negedge clk);
        i_trigger_return = 1'b0;
    endtask

    task automatic insert(input int k);
        i_input_coin = 3'(1 << k);
        @(negedge clk);
        i_input_coin = '0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (o_return_changes !== 1'b0 || o_return_coin !== '0 || o_total_dec !== '0 || o_wait_time !== '0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got chg=%b coin=%b dec=%0d wait=%0d busy=%b want all 0", o_return_changes, o_return_coin, o_total_dec, o_wait_time, o_busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_wait_time !== '0) begin
            failures++;
            $display("FAIL reset_release got busy=%b wait=%0d want 0/0", o_busy, o_wait_time);
        end
    endtask

    task automatic test_greedy();
        int res;
        set_total(1700);
        trigger();
        res = model_return(1700);
        foreach (exp_q[i]) begin
            checks++;
            if (o_return_changes !== exp_q[i].chg || o_return_coin !== exp_q[i].coin || o_total_dec !== exp_q[i].dec) begin
                failures++;
                $display("FAIL greedy step=%0d got chg=%b coin=%b dec=%0d want chg=%b coin=%b dec=%0d", i, o_return_changes, o_return_coin, o_total_dec, exp_q[i].chg, exp_q[i].coin, exp_q[i].dec);
            end
            @(negedge clk);
        end
        checks++;
        if (cur_total !== 16'(res)) begin
            failures++;
            $display("FAIL greedy_residue got %0d want %0d", cur_total, res);
        end
    endtask

    task automatic test_inactivity();
        int res;
        insert(1);
        for (int j = 0; j <= 100; j++) begin
            checks++;
            if (o_wait_time !== 8'(100 - j) || o_return_changes !== 1'b0) begin
                failures++;
                $display("FAIL inactivity_timer j=%0d got wait=%0d chg=%b want wait=%0d chg=0", j, o_wait_time, o_return_changes, 100 - j);
            end
            @(negedge clk);
        end
        res = model_return(500);
        foreach (exp_q[i]) begin
            checks++;
            if (o_return_changes !== exp_q[i].chg || o_return_coin !== exp_q[i].coin || o_total_dec !== exp_q[i].dec) begin
                failures++;
                $display("FAIL inactivity_return step=%0d got chg=%b coin=%b dec=%0d want chg=%b coin=%b dec=%0d", i, o_return_changes, o_return_coin, o_total_dec, exp_q[i].chg, exp_q[i].coin, exp_q[i].dec);
            end
            @(negedge clk);
        end
        checks++;
        if (cur_total !== 16'(res)) begin
            failures++;
            $display("FAIL inactivity_residue got %0d want %0d", cur_total, res);
        end
    endtask

    task automatic test_reload();
        int res;
        insert(0);
        repeat (60) @(negedge clk);
        checks++;
        if (o_wait_time !== 8'd40) begin
            failures++;
            $display("FAIL reload_before got wait=%0d want 40", o_wait_time);
        end
        insert(0);
        for (int j = 0; j <= 100; j++) begin
            checks++;
            if (o_wait_time !== 8'(100 - j) || o_return_changes !== 1'b0) begin
                failures++;
                $display("FAIL reload_timer j=%0d got wait=%0d chg=%b want wait=%0d chg=0", j, o_wait_time, o_return_changes, 100 - j);
            end
            @(negedge clk);
        end
        res = model_return(200);
        foreach (exp_q[i]) begin
            checks++;
            if (o_return_changes !== exp_q[i].chg || o_return_coin !== exp_q[i].coin || o_total_dec !== exp_q[i].dec) begin
                failures++;
                $display("FAIL reload_return step=%0d got chg=%b coin=%b dec=%0d want chg=%b coin=%b dec=%0d", i, o_return_changes, o_return_coin, o_total_dec, exp_q[i].chg, exp_q[i].coin, exp_q[i].dec);
            end
            @(negedge clk);
        end
        checks++;
        if (cur_total !== 16'(res)) begin
            failures++;
            $display("FAIL reload_residue got %0d want %0d", cur_total, res);
        end
    endtask

    task automatic test_simultaneous();
        int res;
        set_total(300);
        insert(0);
        i_input_coin     = 3'b001;
        i_trigger_return = 1'b1;
        @(negedge clk);
        i_input_coin     = '0;
        i_trigger_return = 1'b0;
        res = model_return(500);
        foreach (exp_q[i]) begin
            checks++;
            if (o_return_changes !== exp_q[i].chg || o_return_coin !== exp_q[i].coin || o_total_dec !== exp_q[i].dec) begin
                failures++;
                $display("FAIL simul_return step=%0d got chg=%b coin=%b dec=%0d want chg=%b coin=%b dec=%0d", i, o_return_changes, o_return_coin, o_total_dec, exp_q[i].chg, exp_q[i].coin, exp_q[i].dec);
            end
            @(negedge clk);
        end
        checks++;
        if (cur_total !== 16'(res)) begin
            failures++;
            $display("FAIL simul_residue got %0d want %0d", cur_total, res);
        end
    endtask

    task automatic test_residue();
        int res;
        set_total(150);
        trigger();
        res = model_return(150);
        foreach (exp_q[i]) begin
            checks++;
            if (o_return_changes !== exp_q[i].chg || o_return_coin !== exp_q[i].coin || o_total_dec !== exp_q[i].dec) begin
                failures++;
                $display("FAIL residue_return step=%0d got chg=%b coin=%b dec=%0d want chg=%b coin=%b dec=%0d", i, o_return_changes, o_return_coin, o_total_dec, exp_q[i].chg, exp_q[i].coin, exp_q[i].dec);
            end
            @(negedge clk);
        end
        checks++;
        if (cur_total !== 16'(res)) begin
            failures++;
            $display("FAIL residue_left got %0d want %0d", cur_total, res);
        end
        trigger();
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (o_busy !== 1'b0 || o_return_coin !== '0) begin
                failures++;
                $display("FAIL residue_retrigger j=%0d got busy=%b coin=%b want 0/0", j, o_busy, o_return_coin);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_expiry_zero();
        int res;
        set_total(0);
        i_item_dispensed = 1'b1;
        @(negedge clk);
        i_item_dispensed = 1'b0;
        checks++;
        if (o_wait_time !== 8'd100 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL dispense_activity got wait=%0d busy=%b want 100/1", o_wait_time, o_busy);
        end
        repeat (101) @(negedge clk);
        res = model_return(0);
        foreach (exp_q[i]) begin
            checks++;
            if (o_return_changes !== exp_q[i].chg || o_return_coin !== exp_q[i].coin || o_total_dec !== exp_q[i].dec) begin
                failures++;
                $display("FAIL expiry_zero step=%0d got chg=%b coin=%b dec=%0d want chg=%b coin=%b dec=%0d", i, o_return_changes, o_return_coin, o_total_dec, exp_q[i].chg, exp_q[i].coin, exp_q[i].dec);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int base, tot, res, k;
        for (int it = 0; it < 10; it++) begin
            base = $urandom_range(100, 4500);
            set_total(base);
            tot = base;
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 2);
                insert(k);
                tot += val_tab[k];
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
            trigger();
            res = model_return(tot);
            foreach (exp_q[i]) begin
                checks++;
                if (o_return_changes !== exp_q[i].chg || o_return_coin !== exp_q[i].coin || o_total_dec !== exp_q[i].dec) begin
                    failures++;
                    $display("FAIL random it=%0d total=%0d step=%0d got chg=%b coin=%b dec=%0d want chg=%b coin=%b dec=%0d", it, tot, i, o_return_changes, o_return_coin, o_total_dec, exp_q[i].chg, exp_q[i].coin, exp_q[i].dec);
                end
                @(negedge clk);
            end
            checks++;
            if (cur_total !== 16'(res)) begin
                failures++;
                $display("FAIL random_residue it=%0d got %0d want %0d", it, cur_total, res);
            end
        end
    endtask

    task automatic test_reset_mid_return();
        set_total(3000);
        trigger();
        checks++;
        if (o_total_dec !== 16'd1000 || o_return_coin !== 3'b100) begin
            failures++;
            $display("FAIL midreset_first got coin=%b dec=%0d want 100/1000", o_return_coin, o_total_dec);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (o_return_changes !== 1'b0 || o_return_coin !== '0 || o_total_dec !== '0 || o_wait_time !== '0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async got chg=%b coin=%b dec=%0d wait=%0d busy=%b want all 0", o_return_changes, o_return_coin, o_total_dec, o_wait_time, o_busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_return_coin !== '0 || cur_total !== '0) begin
            failures++;
            $display("FAIL midreset_after got busy=%b coin=%b total=%0d want 0/0/0", o_busy, o_return_coin, cur_total);
        end
    endtask

    initial begin
        test_reset();
        test_greedy();
        test_inactivity();
        test_reload();
        test_simultaneous();
        test_residue();
        test_expiry_zero();
        test_random();
        test_reset_mid_return();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
